// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU classes, mux selects.
// Pure definitions; no timing or flow control of its own.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_RTEXEC = 4'd7,
    ST_RTWB   = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_HALT   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational datapath-control decode from the current FSM state.
// Zero latency; only pc_en/ir_write follow mem_ready/zero, illegal follows opcode in DECODE.
module mc_out_decode
  import mc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_BROFF;
        // In skip mode the DECODE cycle is the only place an unknown opcode is visible.
        ctrl_o.illegal   = !HALT_ON_ILLEGAL && !is_legal_op(opcode_i);
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_RTEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ST_RTWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_source = PC_ALUOUT;
        ctrl_o.pc_en     = zero_i;
      end
      ST_JUMP: begin
        ctrl_o.pc_source = PC_JUMP;
        ctrl_o.pc_en     = 1'b1;
      end
      ST_HALT: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM: next-state logic here, output decode in mc_out_decode.
// Outputs follow state combinationally; FETCH/MEMRD/MEMWR wait on mem_ready, reset drops everything at once.
module mc_control
  import mc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_RTEXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default:      state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_RTEXEC: state_d = ST_RTWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_MEMWB, ST_RTWB, ST_ADDIWB, ST_BRANCH, ST_JUMP:
                 state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      // Unused encodings can only be reached by corruption; park safely.
      default:   state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  mc_out_decode #(
    .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
  ) u_out_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (ctrl)
  );

  assign pc_en      = ctrl.pc_en;
  assign ir_write   = ctrl.ir_write;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal    = ctrl.illegal;
  assign state      = state_q;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 = enter HALT on an unknown opcode; 0 = skip the instruction and refetch.
REQ-002 SHALL have clk input, 1 bit: system clock, rising edge active.
REQ-003 SHALL have rst_n input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have opcode input, 6 bits: instruction[31:26], valid from DECODE onward.
REQ-005 SHALL have zero input, 1 bit: ALU zero flag, sampled in BRANCH.
REQ-006 SHALL have mem_ready input, 1 bit: memory handshake; the access completes in the cycle it is 1.
REQ-007 SHALL have outputs pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg and alu_src_a, 1 bit each: datapath enables and mux selects.
REQ-008 SHALL have outputs alu_src_b, alu_op and pc_source, 2 bits each: operand-B select, ALU class and next-PC select.
REQ-009 SHALL have output illegal, 1 bit: unknown-opcode indication.
REQ-010 SHALL have output state, 4 bits: current state, for debug.

Function
REQ-011 SHALL be a Moore FSM; outputs decode from state, except that pc_en and ir_write also depend on mem_ready and zero.
REQ-012 SHALL use states IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEXEC=7, RTWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=15.
REQ-013 SHALL go IDLE->FETCH unconditionally on the first clock after rst_n rises.
REQ-014 SHALL in FETCH drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_source=00; ir_write and pc_en SHALL equal mem_ready; FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-015 SHALL in DECODE drive alu_src_a=0, alu_src_b=11 (branch target precompute) and branch on opcode.
REQ-016 SHALL in DECODE route opcode 000000 to RTEXEC, 100011 and 101011 to MEMADR, 000100 to BRANCH, 000010 to JUMP and 001000 to ADDIEX.
REQ-017 SHALL in DECODE route any other opcode to HALT if HALT_ON_ILLEGAL=1, otherwise to FETCH with illegal=1 for that DECODE cycle only.
REQ-018 SHALL in MEMADR drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEMRD if opcode=100011, else to MEMWR.
REQ-019 SHALL in MEMRD and MEMWR hold mem_read=1 or mem_write=1 respectively, with iord=1, while mem_ready=0; on mem_ready=1 MEMRD SHALL go to MEMWB and MEMWR to FETCH.
REQ-020 SHALL in MEMWB drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-021 SHALL go RTEXEC (alu_src_a=1, alu_src_b=00, alu_op=10) -> RTWB (reg_write=1, reg_dst=1, mem_to_reg=0) -> FETCH.
REQ-022 SHALL go ADDIEX (alu_src_a=1, alu_src_b=10, alu_op=00) -> ADDIWB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
REQ-023 SHALL in BRANCH drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01 and pc_en=zero, then go to FETCH.
REQ-024 SHALL in JUMP drive pc_source=10 and pc_en=1, then go to FETCH.
REQ-025 SHALL drive every output not listed for a state to 0.
REQ-026 SHALL with mem_ready=1 complete each instruction in these cycles, FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-027 SHALL stay in HALT with illegal=1 and all enables 0 until reset.
REQ-028 SHALL assert at most one of mem_read and mem_write in any cycle.
REQ-029 SHALL never assert pc_en and reg_write in the same cycle.

Reset
REQ-030 SHALL on rst_n=0 immediately force state=IDLE and all outputs to 0, including pc_en, mem_read, mem_write and illegal, from any state.
REQ-031 SHALL abandon a pending handshake when reset is asserted mid-access, and restart at FETCH after release.

Structure
REQ-032 SHALL place state encodings, opcode constants and alu_op encodings (ADD=00, SUB=01, FUNCT=10) in the shared package mc_pkg.
REQ-033 SHALL split the output decode into one combinational sub-module, mc_out_decode, with next-state logic kept in mc_control.

Verification
REQ-034 SHALL check: reset release, mem_ready=1, instruction 0x20040008 -> states 1,2,11,12,1; reg_write=1 only in ADDIWB; reg_dst=0.
REQ-035 SHALL check: lw opcode 100011, mem_ready=0 for 2 cycles in MEMRD -> mem_read and iord held 3 cycles; 7 cycles total; MEMWB has mem_to_reg=1.
REQ-036 SHALL check: beq with zero=1 -> pc_en=1 and pc_source=01 in BRANCH; with zero=0 -> pc_en=0; both take 3 cycles.
REQ-037 SHALL check: opcode 110010 with HALT_ON_ILLEGAL=1 -> state=15, illegal=1 held for 10 cycles; with HALT_ON_ILLEGAL=0 -> illegal for 1 cycle, then FETCH.
REQ-038 SHALL check: rst_n low mid-MEMWR with mem_ready=0 -> mem_write=0 and state=0 in the same cycle; FETCH one cycle after release.
REQ-039 SHALL check: FETCH with mem_ready=0 for 3 cycles -> ir_write=0 and pc_en=0 throughout; both 1 in exactly the ready cycle.
